cra_diag_master: RTL and testbench

//  EBUS diagnostic initiator for the CRA. It loads an 11-bit CRAM diagnostic address with two DIAG

---
 rtl/kl10_diag_pkg.sv | 25 ++
 rtl/cra_diag_master_if.sv | 32 +++
 rtl/diag_hold_timer.sv | 27 ++
 rtl/cra_diag_master.sv | 193 +++++++++++++++++++
 tb/tb_cra_diag_master.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/kl10_diag_pkg.sv
// Shared DIAG function codes, FSM state encoding and hold-count helper for the CRA diagnostic initiator.
package kl10_diag_pkg;

  localparam logic [8:0] DIAG_LDADR_LO = 9'o051;
  localparam logic [8:0] DIAG_LDADR_HI = 9'o052;
  localparam logic [8:0] DIAG_RD_BASE  = 9'o140;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W51_SET = 4'd1,
    W51_STB = 4'd2,
    W52_SET = 4'd3,
    W52_STB = 4'd4,
    R_SET   = 4'd5,
    R_WAIT  = 4'd6,
    R_CAP   = 4'd7,
    DONE    = 4'd8
  } diag_state_e;

  // A hold of N clocks loads N-1 so that the counter reaching zero ends the hold; 0 still holds one clock.
  function automatic int hold_load(input int n);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/cra_diag_master_if.sv
// Command/response and EBUS diagnostic signal bundle for cra_diag_master.
interface cra_diag_master_if;
  // A command transfers on a clock where cmdValid and cmdReady are both high; cmdReady stays low
  // until the cycle after the rspValid pulse, and cmdValid while busy is simply ignored.
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdRead;
  logic [0:10] cmdAdr;
  logic [0:2]  cmdSel;
  logic        rspValid;
  logic [0:5]  rspData;
  logic        errTimeout;
  logic        errVerify;
  logic [0:8]  diagFunc;
  logic        diagStrobe;
  logic [0:35] ebusOut;
  logic        ebusDriveEn;
  logic [0:35] EBUS;
  logic        CRAdrivingEBUS;

  modport master (
    input  cmdValid, cmdRead, cmdAdr, cmdSel, EBUS, CRAdrivingEBUS,
    output cmdReady, rspValid, rspData, errTimeout, errVerify,
           diagFunc, diagStrobe, ebusOut, ebusDriveEn
  );

  modport slave (
    output cmdValid, cmdRead, cmdAdr, cmdSel, EBUS, CRAdrivingEBUS,
    input  cmdReady, rspValid, rspData, errTimeout, errVerify,
           diagFunc, diagStrobe, ebusOut, ebusDriveEn
  );
endinterface

// File: rtl/diag_hold_timer.sv
// Loadable saturating down-counter; done is high while the count sits at zero.
module diag_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/cra_diag_master.sv
// EBUS diagnostic initiator: loads the CRAM diag address (DIAG 051/052) and reads CRA status (DIAG 14x).
// Optional readback check of the loaded address is built when CRA_DIAG_VERIFY_EN is defined.
module cra_diag_master
  import kl10_diag_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cra_diag_master_if.master    bus,
  output logic [3:0]           dbg_state
);

  localparam int MAX_HOLD = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(hold_load(SETTLE_CYCLES));
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(hold_load(TIMEOUT_CYCLES));

  diag_state_e state_q, state_d;
  logic [0:10] adr_q, adr_d;
  logic [0:2]  sel_q, sel_d;
  logic [0:5]  rsp_data_q, rsp_data_d;
  logic        err_timeout_q, err_timeout_d;
  logic        settle_load, settle_done, tmo_load, tmo_done;
`ifdef CRA_DIAG_VERIFY_EN
  logic        err_verify_q, err_verify_d;
  logic [1:0]  vphase_q, vphase_d;
`endif

  // Two timers: the timeout must keep running while a settle hold restarts inside R_CAP.
  diag_hold_timer #(.W(CNT_W)) u_settle (
    .clk(clk), .rst_n(rst_n), .load(settle_load), .load_val(SETTLE_LD), .done(settle_done)
  );
  diag_hold_timer #(.W(CNT_W)) u_tmo (
    .clk(clk), .rst_n(rst_n), .load(tmo_load), .load_val(TMO_LD), .done(tmo_done)
  );

  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    sel_d         = sel_q;
    rsp_data_d    = rsp_data_q;
    err_timeout_d = err_timeout_q;
    settle_load   = 1'b0;
    tmo_load      = 1'b0;
`ifdef CRA_DIAG_VERIFY_EN
    err_verify_d  = err_verify_q;
    vphase_d      = vphase_q;
`endif
    case (state_q)
      IDLE: if (bus.cmdValid) begin
        adr_d         = bus.cmdAdr;
        sel_d         = bus.cmdSel;
        rsp_data_d    = '0;
        err_timeout_d = 1'b0;
        settle_load   = 1'b1;
        state_d       = bus.cmdRead ? R_SET : W51_SET;
`ifdef CRA_DIAG_VERIFY_EN
        err_verify_d  = 1'b0;
        vphase_d      = 2'd0;
`endif
      end
      W51_SET: if (settle_done) state_d = W51_STB;
      W51_STB: begin
        settle_load = 1'b1;
        state_d     = W52_SET;
      end
      W52_SET: if (settle_done) state_d = W52_STB;
      W52_STB: begin
`ifdef CRA_DIAG_VERIFY_EN
        sel_d       = 3'd4;
        vphase_d    = 2'd1;
        settle_load = 1'b1;
        state_d     = R_SET;
`else
        state_d     = DONE;
`endif
      end
      R_SET: if (settle_done) begin
        tmo_load = 1'b1;
        state_d  = R_WAIT;
      end
      R_WAIT: begin
        if (bus.CRAdrivingEBUS) begin
          settle_load = 1'b1;
          state_d     = R_CAP;
        end else if (tmo_done) begin
          err_timeout_d = 1'b1;
          rsp_data_d    = '0;
          state_d       = DONE;
        end
      end
      R_CAP: begin
        if (!bus.CRAdrivingEBUS) begin
          state_d = R_WAIT;
        end else if (settle_done) begin
`ifdef CRA_DIAG_VERIFY_EN
          case (vphase_q)
            2'd1: begin
              if (bus.EBUS[0:5] != adr_q[5:10]) err_verify_d = 1'b1;
              sel_d       = 3'd5;
              vphase_d    = 2'd2;
              settle_load = 1'b1;
              state_d     = R_SET;
            end
            2'd2: begin
              // EBUS bit 0 carries parity on the 145 readback and is not compared.
              if (bus.EBUS[1:5] != adr_q[0:4]) err_verify_d = 1'b1;
              state_d = DONE;
            end
            default: begin
              rsp_data_d = bus.EBUS[0:5];
              state_d    = DONE;
            end
          endcase
`else
          rsp_data_d = bus.EBUS[0:5];
          state_d    = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      adr_q         <= '0;
      sel_q         <= '0;
      rsp_data_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      adr_q         <= adr_d;
      sel_q         <= sel_d;
      rsp_data_q    <= rsp_data_d;
      err_timeout_q <= err_timeout_d;
    end
  end

`ifdef CRA_DIAG_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_verify_q <= 1'b0;
      vphase_q     <= 2'd0;
    end else begin
      err_verify_q <= err_verify_d;
      vphase_q     <= vphase_d;
    end
  end
`endif

  // Bus outputs decode straight from the state register so reset releases them asynchronously.
  always_comb begin
    bus.cmdReady    = (state_q == IDLE);
    bus.rspValid    = (state_q == DONE);
    bus.rspData     = rsp_data_q;
    bus.errTimeout  = err_timeout_q;
`ifdef CRA_DIAG_VERIFY_EN
    bus.errVerify   = err_verify_q;
`else
    bus.errVerify   = 1'b0;
`endif
    bus.diagFunc    = '0;
    bus.diagStrobe  = 1'b0;
    bus.ebusOut     = '0;
    bus.ebusDriveEn = 1'b0;
    case (state_q)
      W51_SET, W51_STB: begin
        bus.diagFunc      = DIAG_LDADR_LO;
        bus.ebusOut[0:5]  = adr_q[5:10];
        bus.ebusDriveEn   = 1'b1;
        bus.diagStrobe    = (state_q == W51_STB);
      end
      W52_SET, W52_STB: begin
        bus.diagFunc      = DIAG_LDADR_HI;
        bus.ebusOut[1:5]  = adr_q[0:4];
        bus.ebusDriveEn   = 1'b1;
        bus.diagStrobe    = (state_q == W52_STB);
      end
      R_SET, R_WAIT, R_CAP: bus.diagFunc = DIAG_RD_BASE | {6'b0, sel_q};
      default: ;
    endcase
  end

  logic unused_ebus;
  assign unused_ebus = ^bus.EBUS[6:35];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cra_diag_master.sv
// Self-checking bench for cra_diag_master: scoreboarded strobes/responses plus a small CRA read model.
module tb_cra_diag_master;
  import kl10_diag_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dbg_state;

  cra_diag_master_if bus();

  cra_diag_master #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

`ifdef CRA_DIAG_VERIFY_EN
  localparam int LOAD_LAT = -1;
`else
  localparam int LOAD_LAT = 11;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard
  logic [44:0] exp_q[$];      // {diagFunc, ebusOut} per expected strobe
  logic [7:0]  exp_rsp_q[$];  // {errVerify, errTimeout, rspData} per expected response
  int          exp_lat = -1;
  int          acc_cyc = 0;
  int          rsp_cnt = 0;
  logic        drv_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ebusDriveEn) drv_seen = 1'b1;
      if (bus.diagStrobe) begin
        if (exp_q.size() == 0) chk("stb_unexp", bus.diagStrobe, 1'b0);
        else chk("strobe", {bus.diagFunc, bus.ebusOut}, exp_q.pop_front());
      end
      if (bus.rspValid) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexp", bus.rspValid, 1'b0);
        else chk("rsp", {bus.errVerify, bus.errTimeout, bus.rspData}, exp_rsp_q.pop_front());
        if (exp_lat >= 0) chk("latency", cyc - acc_cyc, exp_lat);
        rsp_cnt++;
      end
    end
  end

  // CRA model: starts driving EBUS[0:5] cra_delay clocks after a DIAG 14x read appears
  logic [0:5] cra_resp[8];
  int         cra_delay = 3;
  bit         cra_en = 1'b0;
  bit         cra_corrupt = 1'b0;
  int         cra_cnt = 0;

  always @(negedge clk) begin
    if (bus.diagFunc[0:5] == 6'o14 && cra_en) begin
      cra_cnt++;
      if (cra_cnt >= cra_delay) begin
        bus.CRAdrivingEBUS = 1'b1;
        bus.EBUS = {cra_resp[bus.diagFunc[6:8]], 30'b0};
      end
    end else begin
      cra_cnt = 0;
      bus.CRAdrivingEBUS = 1'b0;
      bus.EBUS = '0;
    end
  end

  // driver tasks
  task automatic send_cmd(input bit rd, input logic [0:10] adr, input logic [0:2] sel, input int lat);
    int n = 0;
    @(negedge clk);
    while (!bus.cmdReady && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("ready_wait", bus.cmdReady, 1'b1);
    bus.cmdValid = 1'b1;
    bus.cmdRead  = rd;
    bus.cmdAdr   = adr;
    bus.cmdSel   = sel;
    exp_lat      = lat;
    acc_cyc      = cyc;
    @(negedge clk);
    bus.cmdValid = 1'b0;
  endtask

  task automatic send_load(input logic [0:10] adr, input bit ev);
    logic [0:5] v;
    v = adr[5:10];
    if (cra_corrupt) v[2] = ~v[2];
    cra_resp[4] = v;
    cra_resp[5] = {1'b1, adr[0:4]};
    cra_en      = 1'b1;
    cra_delay   = 1;
    exp_q.push_back({9'o051, adr[5:10], 30'b0});
    exp_q.push_back({9'o052, 1'b0, adr[0:4], 30'b0});
    exp_rsp_q.push_back({ev, 1'b0, 6'o00});
    send_cmd(1'b0, adr, 3'd0, LOAD_LAT);
  endtask

  task automatic send_read(input logic [0:2] sel, input logic [0:5] data, input bit tmo, input int lat);
    exp_rsp_q.push_back({1'b0, tmo, data});
    send_cmd(1'b1, 11'o0, sel, lat);
  endtask

  task automatic wait_rsp(input int budget);
    int start;
    start = rsp_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_cnt != start) break;
    end
    if (rsp_cnt == start) chk("rsp_wait", rsp_cnt, start + 1);
  endtask

  initial begin
    bus.cmdValid = 1'b0;
    bus.cmdRead  = 1'b0;
    bus.cmdAdr   = '0;
    bus.cmdSel   = '0;
    for (int i = 0; i < 8; i++) cra_resp[i] = 6'(i);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",  bus.cmdReady, 1'b1);
    chk("rst_rspv",   bus.rspValid, 1'b0);
    chk("rst_func",   bus.diagFunc, 9'o000);
    chk("rst_stb",    bus.diagStrobe, 1'b0);
    chk("rst_drv",    bus.ebusDriveEn, 1'b0);
    chk("rst_ebus",   bus.ebusOut, 36'o0);
    chk("rst_tmo",    bus.errTimeout, 1'b0);
    chk("rst_data",   bus.rspData, 6'o00);
    chk("rst_state",  dbg_state, IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // loads: all ones, all zeros, mixed pattern
    send_load(11'o1777, 1'b0);
    wait_rsp(100);
    send_load(11'o0000, 1'b0);
    wait_rsp(100);
    send_load(11'o1234, 1'b0);
    wait_rsp(100);

    // read sel=4, CRA drives 6'o25 after 3 clocks
    cra_en = 1'b1;
    cra_delay = 3;
    cra_resp[4] = 6'o25;
    drv_seen = 1'b0;
    send_read(3'd4, 6'o25, 1'b0, 10);
    chk("rd_func", bus.diagFunc, 9'o144);
    wait_rsp(100);
    chk("rd_drive", drv_seen, 1'b0);

    // read with no CRA response times out
    cra_en = 1'b0;
    send_read(3'd2, 6'o00, 1'b1, 260);
    chk("tmo_func", bus.diagFunc, 9'o142);
    wait_rsp(400);
    repeat (3) @(negedge clk);
    chk("tmo_sticky", bus.errTimeout, 1'b1);
    send_load(11'o0123, 1'b0);
    chk("tmo_clear", bus.errTimeout, 1'b0);
    wait_rsp(100);

    // reset during W52_SET
    send_load(11'o1652, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (dbg_state == W52_SET) break;
      @(negedge clk);
    end
    chk("w52_wait", dbg_state, W52_SET);
    rst_n = 1'b0;
    #1;
    chk("abort_func",  bus.diagFunc, 9'o000);
    chk("abort_ebus",  bus.ebusOut, 36'o0);
    chk("abort_drv",   bus.ebusDriveEn, 1'b0);
    chk("abort_stb",   bus.diagStrobe, 1'b0);
    chk("abort_ready", bus.cmdReady, 1'b1);
    exp_q.delete();
    exp_rsp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send_load(11'o0777, 1'b0);
    wait_rsp(100);

`ifdef CRA_DIAG_VERIFY_EN
    // readback corrupts adr[7], then a clean readback
    cra_corrupt = 1'b1;
    send_load(11'o1234, 1'b1);
    wait_rsp(200);
    cra_corrupt = 1'b0;
    send_load(11'o1234, 1'b0);
    wait_rsp(200);
`endif

    repeat (4) @(negedge clk);
    chk("stb_left", exp_q.size(), 0);
    chk("rsp_left", exp_rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
